module_tick_gen: RTL and testbench
==================================

# module_tick_gen

Multi-channel, runtime-programmable tick and clock-enable generator. It succeeds the single fixed-count divider. Each channel holds its own period register and output mode: single-cycle pulse or 50%-style toggle. A valid/ready configuration port reprograms channels, and a global sync realigns all channels. The block sits between the system clock and slow consumers such as debouncers, display scanners and LED blinkers.

## Interface
- CHANNELS, 4: number of independent channels (1..16).
- WIDTH, 24: width of the period and counter per channel.
- DEFAULT_PERIOD, 1350000: period loaded into every channel at reset. Must fit in WIDTH bits.
- DEFAULT_MODE, MODE_TOGGLE: mode loaded into every channel at reset.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- en  in  CHANNELS  per-channel count enable.
- sync  in  1  global realign: clears all counters and outputs.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration port can accept.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_period  in  WIDTH  new period P.
- cfg_mode  in  1  0 = MODE_PULSE, 1 = MODE_TOGGLE.
- tick  out  CHANNELS  one-cycle pulse at each channel wrap, independent of mode.
- wave  out  CHANNELS  mode output: equals tick in PULSE mode; toggles at each wrap in TOGGLE mode.

## Operation
- Each channel has a counter cnt in 0..P-1. On a cycle where en[i]=1 and P≥1:
  - if cnt==P-1, then cnt←0 and the channel wraps;
  - otherwise cnt←cnt+1.
- When en[i]=0, cnt, tick and wave hold their values, except that tick is forced to 0.
- P==0 halts the channel: cnt holds at 0 and tick=wave=0.
- P==1: tick is high every enabled cycle. In TOGGLE mode, wave toggles every cycle.
- Configuration FSM, states CFG_IDLE and CFG_APPLY:
  - CFG_IDLE: cfg_ready=1. When cfg_valid=1, capture cfg_ch, cfg_period and cfg_mode, then go to CFG_APPLY.
  - CFG_APPLY: cfg_ready=0. Write the period and mode into the target channel, clear its cnt, tick and wave, then return to CFG_IDLE.
  - Maximum throughput is one configuration every 2 cycles.
  - cfg_ch ≥ CHANNELS: the request is accepted and the FSM cycles normally, but no channel changes.
- sync=1: all counters ←0 and all tick/wave ←0. Registered periods and modes are kept.
- Priority, highest first: rst, sync, CFG_APPLY on that channel, normal counting.
  - sync and CFG_APPLY in the same cycle: the apply still writes period and mode, and the sync clear wins on cnt and outputs.
  - A handshake accepted while sync=1 is still accepted.
- Reset state:
  - all cnt=0;
  - periods = DEFAULT_PERIOD, modes = DEFAULT_MODE;
  - tick=0, wave=0, cfg_ready=1, FSM in CFG_IDLE.
- Counter arithmetic is WIDTH-bit unsigned, and the compare is against P-1. With P=2^WIDTH-1 the counter never overflows.

## Timing
- tick and wave are registered outputs, with no combinational path from any input.
- With en[i] held high from the first edge after reset release, the first tick[i] is high in cycle P, counting that first edge as cycle 1. After that, tick[i] is high one cycle in every P.
- TOGGLE mode period is 2P cycles. wave changes on the same edge that tick rises.
- Configuration accepted at edge k: the apply happens at edge k+1, and counting resumes from 0 at edge k+2. The first new tick is at edge k+1+P.
- cfg_ready drops on the edge after acceptance and returns one cycle later.
- rst asserted mid-operation returns everything to the reset state on the next edge, including discarding an apply that is in flight.

## Structure
- Package tick_gen_pkg holds:
  - typedef enum logic {MODE_PULSE, MODE_TOGGLE} tick_mode_e;
  - typedef enum logic {CFG_IDLE, CFG_APPLY} cfg_state_e.
- Sub-module tick_channel (per-channel period/mode registers, counter, tick and wave) is instantiated CHANNELS times in a generate loop.
- The top level contains only the configuration FSM, the channel decode and the sync fan-out.

## Test plan
- Reset, CHANNELS=2, WIDTH=8, DEFAULT_PERIOD=5, TOGGLE, en=11 → tick high in cycles 5, 10, 15; wave reads 1, 0, 1 after those edges.
- Config ch0, P=3, PULSE, accepted at cycle 20 → cfg_ready low in cycle 21; ticks at cycles 24, 27, 30; wave identical to tick; ch1 unaffected.
- Back-to-back cfg_valid held high for 4 cycles → exactly 2 accepts; cfg_ready pattern 1,0,1,0.
- en[0]=0 for 7 cycles mid-count at cnt=2 (P=5) → no tick while disabled; the next tick comes 3 enabled cycles after re-enable.
- sync pulse at cycle 13 with both channels mid-count → tick=wave=0 at cycle 14; next ticks at cycle 13+P per channel.
- P=0 on ch1, P=1 on ch0; cfg_ch=3 with CHANNELS=2 → ch1 silent, ch0 tick constant 1, out-of-range write changes nothing; rst mid-CFG_APPLY → defaults restored.

Source files
------------

// File: rtl/module_tick_gen_pkg.sv
// Shared types for the multi-channel tick generator: channel output modes,
// configuration FSM states and the channel-select width helper.
package tick_gen_pkg;

    typedef enum logic {
        MODE_PULSE,
        MODE_TOGGLE
    } tick_mode_e;

    typedef enum logic {
        CFG_IDLE,
        CFG_APPLY
    } cfg_state_e;

    // Channel select is at least one bit wide even for a single channel.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/module_tick_gen_if.sv
// Valid/ready configuration port of the tick generator: the master issues
// channel/period/mode writes, the slave (the generator) accepts them.
interface module_tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 24
);

    localparam int unsigned CH_W = ch_width(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_period;
    tick_mode_e       cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/module_tick_gen_tick_channel.sv
// One tick channel: period/mode registers, wrap counter and registered
// tick/wave outputs. Clear sources: sync, an apply to this channel, or P==0.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned      WIDTH          = 24,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(1350000),
    parameter tick_mode_e       DEFAULT_MODE   = MODE_TOGGLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             apply,
    input  logic [WIDTH-1:0] apply_period,
    input  tick_mode_e       apply_mode,
    output logic             tick,
    output logic             wave
);

    logic [WIDTH-1:0] period;
    tick_mode_e       mode;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            period <= DEFAULT_PERIOD;
            mode   <= DEFAULT_MODE;
            cnt    <= '0;
            tick   <= 1'b0;
            wave   <= 1'b0;
        end else begin
            // The apply always lands in the registers, even when sync wins the clear.
            if (apply) begin
                period <= apply_period;
                mode   <= apply_mode;
            end

            if (sync || apply || (period == '0)) begin
                cnt  <= '0;
                tick <= 1'b0;
                wave <= 1'b0;
            end else if (en) begin
                if (cnt == period - WIDTH'(1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    wave <= (mode == MODE_TOGGLE) ? ~wave : 1'b1;
                end else begin
                    cnt  <= cnt + WIDTH'(1);
                    tick <= 1'b0;
                    if (mode == MODE_PULSE) wave <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
                // In pulse mode wave mirrors tick, so it drops with it.
                if (mode == MODE_PULSE) wave <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/module_tick_gen.sv
// Multi-channel programmable tick / clock-enable generator: configuration
// FSM, channel decode and sync fan-out around CHANNELS tick_channel instances.
module module_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned      CHANNELS       = 4,
    parameter int unsigned      WIDTH          = 24,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(1350000),
    parameter tick_mode_e       DEFAULT_MODE   = MODE_TOGGLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    module_tick_gen_if.slave    cfg,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] wave
);

    localparam int unsigned CH_W = ch_width(CHANNELS);

    cfg_state_e       state;
    logic             ready_q;
    logic [CH_W-1:0]  cap_ch;
    logic [WIDTH-1:0] cap_period;
    tick_mode_e       cap_mode;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CFG_IDLE;
            ready_q    <= 1'b1;
            cap_ch     <= '0;
            cap_period <= '0;
            cap_mode   <= MODE_PULSE;
        end else begin
            case (state)
                CFG_IDLE: begin
                    if (cfg.cfg_valid) begin
                        cap_ch     <= cfg.cfg_ch;
                        cap_period <= cfg.cfg_period;
                        cap_mode   <= cfg.cfg_mode;
                        state      <= CFG_APPLY;
                        ready_q    <= 1'b0;
                    end
                end
                CFG_APPLY: begin
                    state   <= CFG_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= CFG_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = ready_q;

    // Out-of-range channel numbers match no channel, so the apply is dropped.
    logic [CHANNELS-1:0] apply_sel;

    always_comb begin
        apply_sel = '0;
        if (state == CFG_APPLY) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (cap_ch == CH_W'(i)) apply_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tick_channel #(
            .WIDTH         (WIDTH),
            .DEFAULT_PERIOD(DEFAULT_PERIOD),
            .DEFAULT_MODE  (DEFAULT_MODE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en[g]),
            .sync        (sync),
            .apply       (apply_sel[g]),
            .apply_period(cap_period),
            .apply_mode  (cap_mode),
            .tick        (tick[g]),
            .wave        (wave[g])
        );
    end

endmodule

// File: tb/tb_module_tick_gen.sv
// Self-checking bench for module_tick_gen: directed scenarios plus random
// traffic, all checked against a count-based reference model.
module tb_module_tick_gen;
    import tick_gen_pkg::*;

    localparam int unsigned CH = 3;
    localparam int unsigned W  = 8;
    localparam int          DP = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          sync;
    logic [CH-1:0] tick;
    logic [CH-1:0] wave;

    module_tick_gen_if #(.CHANNELS(CH), .WIDTH(W)) cfg_if ();

    module_tick_gen #(
        .CHANNELS      (CH),
        .WIDTH         (W),
        .DEFAULT_PERIOD(8'd5),
        .DEFAULT_MODE  (MODE_TOGGLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .sync(sync),
        .cfg (cfg_if.slave),
        .tick(tick),
        .wave(wave)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Reference model: a channel ticks on every P-th enabled cycle since its
    // last clear; in toggle mode wave is the parity of the wraps so far.
    int            m_period[CH];
    bit            m_pulse[CH];
    int            m_en_cnt[CH];
    int            m_wraps[CH];
    bit [CH-1:0]   m_tick;
    bit [CH-1:0]   m_wave;
    bit            m_ready;
    bit            m_pend;
    int            m_pch;
    int            m_pp;
    bit            m_ppulse;

    task automatic model_step();
        bit apply;
        int ach;
        int ap;
        bit apulse;
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_period[i] = DP;
                m_pulse[i]  = 1'b0;
                m_en_cnt[i] = 0;
                m_wraps[i]  = 0;
            end
            m_tick  = '0;
            m_wave  = '0;
            m_ready = 1'b1;
            m_pend  = 1'b0;
            return;
        end
        apply  = m_pend;
        ach    = m_pch;
        ap     = m_pp;
        apulse = m_ppulse;
        if (m_ready && cfg_if.cfg_valid) begin
            m_pend   = 1'b1;
            m_pch    = int'(cfg_if.cfg_ch);
            m_pp     = int'(cfg_if.cfg_period);
            m_ppulse = (cfg_if.cfg_mode == MODE_PULSE);
            m_ready  = 1'b0;
        end else begin
            m_pend  = 1'b0;
            m_ready = 1'b1;
        end
        for (int i = 0; i < CH; i++) begin
            bit hit;
            int p_old;
            hit   = apply && (ach == i);
            p_old = m_period[i];
            if (hit) begin
                m_period[i] = ap;
                m_pulse[i]  = apulse;
            end
            if (sync || hit || p_old == 0) begin
                m_en_cnt[i] = 0;
                m_wraps[i]  = 0;
                m_tick[i]   = 1'b0;
            end else if (en[i]) begin
                m_en_cnt[i]++;
                if (m_en_cnt[i] % p_old == 0) begin
                    m_tick[i] = 1'b1;
                    m_wraps[i]++;
                end else begin
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_tick[i] = 1'b0;
            end
            m_wave[i] = m_pulse[i] ? m_tick[i] : ((m_wraps[i] % 2) == 1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic send_cfg(input int ch, input int p, input tick_mode_e md);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_period = W'(p);
        cfg_if.cfg_mode   = md;
        cycle();
        cfg_if.cfg_valid  = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = '0; sync = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0;
        cfg_if.cfg_period = '0; cfg_if.cfg_mode = MODE_PULSE;
        cycle();
        cycle();
        vecs++;
        if ({tick, wave, cfg_if.cfg_ready} !== {3'b000, 3'b000, 1'b1}) begin
            errs++;
            $display("FAIL reset tick=%b wave=%b ready=%b required 000/000/1", tick, wave, cfg_if.cfg_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_default_count();
        en = '1;
        for (int c = 1; c <= 16; c++) begin
            bit [CH-1:0] et;
            bit [CH-1:0] ew;
            cycle();
            et = (c % 5 == 0) ? '1 : '0;
            ew = ((c / 5) % 2 == 1) ? '1 : '0;
            vecs++;
            if ({tick, wave} !== {et, ew} || {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL default_count c=%0d tick=%b wave=%b required %b/%b", c, tick, wave, et, ew);
            end
        end
    endtask

    task automatic test_config();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0;
        cfg_if.cfg_period = 8'd3; cfg_if.cfg_mode = MODE_PULSE;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        vecs++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            errs++;
            $display("FAIL config_ready_drop ready=%b required 0", cfg_if.cfg_ready);
        end
        for (int j = 1; j <= 10; j++) begin
            bit et;
            cycle();
            et = (j >= 4) && ((j - 4) % 3 == 0);
            vecs++;
            if (tick[0] !== et || wave[0] !== et || cfg_if.cfg_ready !== 1'b1 ||
                {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL config j=%0d tick=%b wave=%b ready=%b required tick0=%b model %b/%b",
                         j, tick, wave, cfg_if.cfg_ready, et, m_tick, m_wave);
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        bit [3:0] rdy_seen;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2;
        cfg_if.cfg_period = 8'd7; cfg_if.cfg_mode = MODE_TOGGLE;
        for (int k = 0; k < 4; k++) begin
            rdy_seen[3-k] = cfg_if.cfg_ready;
            if (cfg_if.cfg_ready && cfg_if.cfg_valid) accepts++;
            cycle();
            vecs++;
            if ({tick, wave, cfg_if.cfg_ready} !== {m_tick, m_wave, m_ready}) begin
                errs++;
                $display("FAIL back_to_back k=%0d tick=%b wave=%b ready=%b required %b/%b/%b",
                         k, tick, wave, cfg_if.cfg_ready, m_tick, m_wave, m_ready);
            end
        end
        cfg_if.cfg_valid = 1'b0;
        vecs++;
        if (accepts != 2 || rdy_seen !== 4'b1010) begin
            errs++;
            $display("FAIL back_to_back_accepts accepts=%0d ready=%b required 2/1010", accepts, rdy_seen);
        end
        cycle();
    endtask

    task automatic test_enable_gap();
        en = '1;
        send_cfg(0, 5, MODE_TOGGLE);
        cycle();
        cycle();
        en[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            vecs++;
            if (tick[0] !== 1'b0 || {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL enable_gap_off k=%0d tick=%b wave=%b required model %b/%b", k, tick, wave, m_tick, m_wave);
            end
        end
        en[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            cycle();
            vecs++;
            if (tick[0] !== (e == 3) || {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL enable_gap_on e=%0d tick=%b wave=%b required tick0=%b model %b/%b",
                         e, tick, wave, e == 3, m_tick, m_wave);
            end
        end
    endtask

    task automatic test_sync();
        en = '1;
        cycle();
        cycle();
        cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        vecs++;
        if ({tick, wave} !== '0) begin
            errs++;
            $display("FAIL sync_clear tick=%b wave=%b required 000/000", tick, wave);
        end
        for (int j = 1; j <= 8; j++) begin
            cycle();
            vecs++;
            if ((j <= 5 && tick[0] !== (j == 5)) || {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL sync_resume j=%0d tick=%b wave=%b required model %b/%b", j, tick, wave, m_tick, m_wave);
            end
        end
    endtask

    task automatic test_edge_periods();
        en = '1;
        send_cfg(1, 0, MODE_TOGGLE);
        send_cfg(0, 1, MODE_TOGGLE);
        send_cfg(3, 9, MODE_PULSE);
        for (int k = 0; k < 8; k++) begin
            cycle();
            vecs++;
            if (tick[0] !== 1'b1 || tick[1] !== 1'b0 || wave[1] !== 1'b0 ||
                {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL edge_periods k=%0d tick=%b wave=%b required model %b/%b", k, tick, wave, m_tick, m_wave);
            end
        end
    endtask

    task automatic test_rst_mid_apply();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1;
        cfg_if.cfg_period = 8'd2; cfg_if.cfg_mode = MODE_PULSE;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        cycle();
        vecs++;
        if ({tick, wave, cfg_if.cfg_ready} !== {3'b000, 3'b000, 1'b1}) begin
            errs++;
            $display("FAIL rst_mid_apply tick=%b wave=%b ready=%b required 000/000/1", tick, wave, cfg_if.cfg_ready);
        end
        rst = 1'b1;
        en = '1;
        for (int c = 1; c <= 12; c++) begin
            bit [CH-1:0] et;
            cycle();
            et = (c % 5 == 0) ? '1 : '0;
            vecs++;
            if (tick !== et || {tick, wave} !== {m_tick, m_wave}) begin
                errs++;
                $display("FAIL rst_defaults c=%0d tick=%b wave=%b required %b model %b/%b", c, tick, wave, et, m_tick, m_wave);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            en               = CH'($urandom);
            sync             = ($urandom_range(0, 39) == 0);
            rst              = ($urandom_range(0, 299) != 0);
            cfg_if.cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_if.cfg_ch    = 2'($urandom_range(0, 3));
            cfg_if.cfg_period = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 6));
            cfg_if.cfg_mode  = tick_mode_e'($urandom_range(0, 1));
            cycle();
            vecs++;
            if ({tick, wave, cfg_if.cfg_ready} !== {m_tick, m_wave, m_ready}) begin
                errs++;
                $display("FAIL random cyc=%0d tick=%b wave=%b ready=%b required %b/%b/%b",
                         cyc, tick, wave, cfg_if.cfg_ready, m_tick, m_wave, m_ready);
            end
        end
        rst = 1'b1;
        sync = 1'b0;
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_count();
        test_config();
        test_back_to_back();
        test_enable_gap();
        test_sync();
        test_edge_periods();
        test_rst_mid_apply();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
